instruction_fetch_stage: RTL and testbench

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/instruction_fetch_stage_pkg.sv | 18 +
 rtl/if_id_register.sv | 34 +++
 rtl/instruction_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared processor definitions used by the fetch stage and its IF/ID register.
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  // Instruction addresses are word aligned; the two low bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold freezes the contents.
module if_id_register
  import instruction_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] d_instruction,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_pc_plus4,
  input  logic        d_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Reset and flush both leave a NOP bubble; otherwise load unless held.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instruction <= NOP_INSTR;
      pc          <= '0;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (!hold) begin
      instruction <= d_instruction;
      pc          <= d_pc;
      pc_plus4    <= d_pc_plus4;
      valid       <= d_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-entry skid buffer, IF/ID register.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        pc_redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busywait,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  fetch_state_t state, next_state;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] target_q;
  logic [31:0] inflight_addr;
  logic        fetch_done;

  logic        ifid_hold;
  logic        ifid_flush;
  logic [31:0] d_instruction;
  logic [31:0] d_pc;
  logic [31:0] d_pc_plus4;

  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = word_align(redirect_target);
  assign fetch_done  = imem_read && !imem_busywait;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= FETCH;
    else       state <= next_state;
  end

  // Next state: redirect beats stall, stall beats fetch completion.
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (pc_redirect)              next_state = imem_busywait ? DRAIN : FETCH;
        else if (stall && fetch_done) next_state = HOLD;
      end
      HOLD: begin
        if (pc_redirect || !stall)    next_state = FETCH;
      end
      DRAIN: begin
        if (fetch_done)               next_state = FETCH;
      end
      default:                        next_state = FETCH;
    endcase
  end

  // Memory request and IF/ID load/hold/flush selection.
  always_comb begin
    imem_read     = !RESET && (state != HOLD);
    imem_addr     = (state == DRAIN) ? inflight_addr : pc;
    ifid_hold     = 1'b1;
    ifid_flush    = 1'b0;
    d_instruction = imem_rdata;
    d_pc          = pc;
    d_pc_plus4    = pc_plus4;
    case (state)
      FETCH: begin
        if (pc_redirect)     ifid_flush = 1'b1;
        else if (stall)      ifid_hold  = 1'b1;
        else if (fetch_done) ifid_hold  = 1'b0;
        else                 ifid_flush = 1'b1;  // waiting on memory: present a bubble
      end
      HOLD: begin
        if (pc_redirect) begin
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_hold     = 1'b0;
          d_instruction = skid_instr;
          d_pc          = skid_pc;
          d_pc_plus4    = skid_pc + 32'd4;
        end
      end
      DRAIN:   ifid_flush = 1'b1;
      default: ifid_flush = 1'b1;
    endcase
  end

  // PC, skid buffer, and redirect bookkeeping for an access still in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc            <= RESET_PC;
      skid_instr    <= NOP_INSTR;
      skid_pc       <= '0;
      target_q      <= '0;
      inflight_addr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (pc_redirect) begin
            if (imem_busywait) begin
              target_q      <= redirect_pc;
              inflight_addr <= pc;
            end else begin
              pc <= redirect_pc;
            end
          end else if (fetch_done) begin
            pc <= pc_plus4;
            if (stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
            end
          end
        end
        HOLD: begin
          if (pc_redirect) begin
            pc         <= redirect_pc;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
          end
        end
        DRAIN: begin
          // A redirect arriving in the completing cycle still wins over the latched one.
          if (pc_redirect) target_q <= redirect_pc;
          if (fetch_done)  pc       <= pc_redirect ? redirect_pc : target_q;
        end
        default: ;
      endcase
    end
  end

  if_id_register u_if_id_register (
    .clk           (CLK),
    .rst           (RESET),
    .hold          (ifid_hold),
    .flush         (ifid_flush),
    .d_instruction (d_instruction),
    .d_pc          (d_pc),
    .d_pc_plus4    (d_pc_plus4),
    .d_valid       (1'b1),
    .instruction   (if_id_instruction),
    .pc            (if_id_pc),
    .pc_plus4      (if_id_pc_plus4),
    .valid         (if_id_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: per-cycle vector table,
// consumed-instruction scoreboard, and hand sequences for reset corners.
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        busy;

  logic        read0, valid0, read2, valid2;
  logic [31:0] addr0, rdata0, instr0, pc0, pc4_0;
  logic [31:0] addr2, rdata2, instr2, pc2, pc4_2;

  int n_checks = 0;
  int n_errors = 0;
  logic sb_en = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        busy;
    logic        push;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[22];

  always #5 CLK = ~CLK;

  // Instruction memory contents seen by both DUTs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00A00093;
      32'h4:   return 32'h00100113;
      32'h8:   return 32'h002081B3;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign rdata0 = mem_word(addr0);
  assign rdata2 = mem_word(addr2);

  instruction_fetch_stage dut0 (
    .CLK(CLK), .RESET(RESET), .stall(stall), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .imem_read(read0), .imem_addr(addr0),
    .imem_rdata(rdata0), .imem_busywait(busy), .if_id_instruction(instr0),
    .if_id_pc(pc0), .if_id_pc_plus4(pc4_0), .if_id_valid(valid0)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RESET(RESET), .stall(stall), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .imem_read(read2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_busywait(busy), .if_id_instruction(instr2),
    .if_id_pc(pc2), .if_id_pc_plus4(pc4_2), .if_id_valid(valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic b, input logic p, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.target = t; v.busy = b; v.push = p;
    v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  // Decode consumes IF/ID whenever it is valid, not stalled and not squashed.
  always @(negedge CLK) begin
    sb_t e;
    if (sb_en && valid0 && !stall && !pc_redirect) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h with no expected entry", pc0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", pc0, e.pc);
        chk("sb_instr", instr0, e.instr);
        chk("sb_pc_plus4", pc4_0, e.pc + 32'd4);
      end
    end
  end

  initial begin
    //          stall redir target       busy push read addr          valid pc
    vecs[0]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h0,   0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h4,   1, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0,   0, 1, 1, 32'h8,   1, 32'h4);
    vecs[3]  = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4);
    vecs[4]  = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4);
    vecs[5]  = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h4);
    vecs[6]  = mk(0, 0, 32'h0,   0, 0, 1, 32'hC,   1, 32'h8);
    vecs[7]  = mk(1, 1, 32'h102, 0, 0, 1, 32'h10,  1, 32'hC);
    vecs[8]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h100, 0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,   0, 0, 1, 32'h104, 1, 32'h100);
    vecs[10] = mk(0, 1, 32'h40,  1, 0, 1, 32'h108, 1, 32'h104);
    vecs[11] = mk(0, 0, 32'h0,   1, 0, 1, 32'h108, 0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,   1, 0, 1, 32'h108, 0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,   1, 0, 1, 32'h108, 0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,   0, 0, 1, 32'h108, 0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,   0, 1, 1, 32'h40,  0, 32'h0);
    vecs[16] = mk(0, 0, 32'h0,   0, 0, 1, 32'h44,  1, 32'h40);
    vecs[17] = mk(0, 1, 32'h200, 1, 0, 1, 32'h48,  1, 32'h44);
    vecs[18] = mk(0, 1, 32'h303, 1, 0, 1, 32'h48,  0, 32'h0);
    vecs[19] = mk(0, 0, 32'h0,   0, 0, 1, 32'h48,  0, 32'h0);
    vecs[20] = mk(0, 0, 32'h0,   0, 1, 1, 32'h300, 0, 32'h0);
    vecs[21] = mk(0, 0, 32'h0,   0, 0, 1, 32'h304, 1, 32'h300);

    RESET = 1'b1; stall = 1'b0; pc_redirect = 1'b0; redirect_target = '0; busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_read", {31'b0, read0}, 32'h0);
    chk("rst_valid", {31'b0, valid0}, 32'h0);
    chk("rst_instr", instr0, NOP_INSTR);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_pc_plus4", pc4_0, 32'h0);
    chk("rst_read_b", {31'b0, read2}, 32'h0);
    @(posedge CLK);
    #1;

    RESET = 1'b0;
    sb_en = 1'b1;
    for (int unsigned i = 0; i < 22; i++) begin
      vec_t v;
      sb_t  e;
      v = vecs[i];
      stall = v.stall; pc_redirect = v.redir; redirect_target = v.target; busy = v.busy;
      if (v.push) begin
        e.pc = v.exp_addr;
        e.instr = mem_word(v.exp_addr);
        sb_q.push_back(e);
      end
      @(negedge CLK);
      chk($sformatf("row%0d read", i), {31'b0, read0}, {31'b0, v.exp_read});
      if (v.exp_read) chk($sformatf("row%0d addr", i), addr0, v.exp_addr);
      chk($sformatf("row%0d valid", i), {31'b0, valid0}, {31'b0, v.exp_valid});
      chk($sformatf("row%0d instr", i), instr0, v.exp_valid ? mem_word(v.exp_pc) : NOP_INSTR);
      if (v.exp_valid) begin
        chk($sformatf("row%0d pc", i), pc0, v.exp_pc);
        chk($sformatf("row%0d pc_plus4", i), pc4_0, v.exp_pc + 32'd4);
      end
      if (i == 0) begin
        chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_first_read", {31'b0, read2}, 32'h1);
      end
      if (i == 1) begin
        chk("wrap_second_addr", addr2, 32'h0);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc4_2, 32'h0);
        chk("wrap_valid", {31'b0, valid2}, 32'h1);
        chk("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
      end
      @(posedge CLK);
      #1;
    end
    sb_en = 1'b0;
    chk("sb_leftover", sb_q.size(), 32'h0);

    // Enter DRAIN, then reset while the access is still outstanding.
    stall = 1'b0; pc_redirect = 1'b1; redirect_target = 32'h80; busy = 1'b1;
    @(negedge CLK);
    chk("drain_entry_addr", addr0, 32'h308);
    @(posedge CLK);
    #1;
    pc_redirect = 1'b0; redirect_target = '0; RESET = 1'b1;
    @(negedge CLK);
    chk("drain_hold_addr_pre_reset", addr0, 32'h308);
    chk("reset_in_drain_read", {31'b0, read0}, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0; busy = 1'b0;
    @(negedge CLK);
    chk("post_reset_addr", addr0, 32'h0);
    chk("post_reset_read", {31'b0, read0}, 32'h1);
    chk("post_reset_valid", {31'b0, valid0}, 32'h0);
    chk("post_reset_instr", instr0, NOP_INSTR);
    chk("post_reset_pc", pc0, 32'h0);
    chk("post_reset_addr_b", addr2, 32'hFFFF_FFFC);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("post_reset_first_valid", {31'b0, valid0}, 32'h1);
    chk("post_reset_first_pc", pc0, 32'h0);
    chk("post_reset_first_instr", instr0, 32'h00A00093);
    chk("post_reset_next_addr", addr0, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
